// File: rtl/path_pkg.sv
// ---------------------------------------------------------------------------
// path_pkg
// Shared types and defaults for the path planner scheduling slice.
//   NODE_W_DEF / PATH_LEN_DEF : default node index width and path slot count,
//                               matching the path_planner instance.
//   path_t                    : packed final_path word at the default sizes.
//   sched_state_t             : path_query_scheduler FSM states.
// ---------------------------------------------------------------------------
package path_pkg;

  localparam int NODE_W_DEF   = 5;
  localparam int PATH_LEN_DEF = 10;

  typedef logic [PATH_LEN_DEF*NODE_W_DEF-1:0] path_t;

  // Explicit encodings keep the state values stable for anything that
  // still decodes them as raw 3-bit constants.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    PRST   = 3'd2,
    PSTART = 3'd3,
    WAIT   = 3'd4,
    RESP   = 3'd5
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker, shared by several resource
// schedulers. Searches upward from the entry after the pointer, wrapping.
// Ports:
//   req_i   in  N    request vector
//   ptr_i   in  IW   index of the most recently served requester
//   grant_o out N    one-hot grant (all zero when nothing requests)
//   idx_o   out IW   index of the granted requester
//   valid_o out 1    a grant was made
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Walk the N candidates in priority order (ptr+1 first, ptr itself last)
  // and keep the first one that is requesting.
  always_comb begin
    logic [IW-1:0] candIdx;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    candIdx = '0;
    for (int k = 1; k <= N; k++) begin
      candIdx = IW'((int'(ptr_i) + k) % N);
      if (!valid_o && req_i[candIdx]) begin
        valid_o          = 1'b1;
        idx_o            = candIdx;
        grant_o[candIdx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/path_query_scheduler.sv
// ---------------------------------------------------------------------------
// path_query_scheduler
// Shares one path_planner between NUM_REQ requesters. Picks a query by
// round-robin, runs the planner reset/start handshake, waits for done under a
// watchdog and returns the path tagged with the requester id.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/ready            per-requester query handshake (ready = 1-cycle one-hot)
//   req_s_node/req_e_node      packed per-requester start/end nodes
//   rsp_valid/ready            response handshake, response held until accepted
//   rsp_id/path/timeout/cycles response payload
//   pp_reset/start/s_node/e_node  drive path_planner
//   pp_done/pp_final_path      from path_planner
//   busy                       scheduler is not IDLE
// ---------------------------------------------------------------------------
module path_query_scheduler
  import path_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int NODE_W      = NODE_W_DEF,
  parameter int PATH_LEN    = PATH_LEN_DEF,
  parameter int TIMEOUT_CYC = 4096,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int PW  = PATH_LEN * NODE_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*NODE_W-1:0] req_s_node,
  input  logic [NUM_REQ*NODE_W-1:0] req_e_node,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [PW-1:0]             rsp_path,
  output logic                      rsp_timeout,
  output logic [31:0]               rsp_cycles,
  output logic                      pp_reset,
  output logic                      pp_start,
  output logic [NODE_W-1:0]         pp_s_node,
  output logic [NODE_W-1:0]         pp_e_node,
  input  logic                      pp_done,
  input  logic [PW-1:0]             pp_final_path,
  output logic                      busy
);

  sched_state_t      state_q, state_d;
  logic [IDW-1:0]    rrPtr_q, rrPtr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [NODE_W-1:0] sNode_q, sNode_d;
  logic [NODE_W-1:0] eNode_q, eNode_d;
  logic [31:0]       waitCnt_q, waitCnt_d;
  logic [PW-1:0]     path_q, path_d;
  logic              timeout_q, timeout_d;
  logic              abortPend_q, abortPend_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gntIdx;
  logic               gntValid;

  rr_arbiter #(.N(NUM_REQ), .IW(IDW)) uArb (
    .req_i   (req_valid),
    .ptr_i   (rrPtr_q),
    .grant_o (gnt),
    .idx_o   (gntIdx),
    .valid_o (gntValid)
  );

  // Next-state logic. Requester inputs are only looked at in ARB and pp_done
  // only in WAIT, so a done left high by the previous query cannot leak into
  // the next one. The wait counter is cleared when a grant is made, i.e. on
  // entry to PRST, and ends up holding the number of WAIT cycles spent.
  always_comb begin
    state_d     = state_q;
    rrPtr_d     = rrPtr_q;
    id_d        = id_q;
    sNode_d     = sNode_q;
    eNode_d     = eNode_q;
    waitCnt_d   = waitCnt_q;
    path_d      = path_q;
    timeout_d   = timeout_q;
    abortPend_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) state_d = ARB;
      end
      ARB: begin
        if (gntValid) begin
          id_d      = gntIdx;
          rrPtr_d   = gntIdx;
          sNode_d   = req_s_node[gntIdx*NODE_W +: NODE_W];
          eNode_d   = req_e_node[gntIdx*NODE_W +: NODE_W];
          waitCnt_d = '0;
          path_d    = '0;
          timeout_d = 1'b0;
          state_d   = PRST;
        end else begin
          state_d = IDLE;
        end
      end
      PRST:   state_d = PSTART;
      PSTART: state_d = WAIT;
      WAIT: begin
        waitCnt_d = (waitCnt_q == '1) ? waitCnt_q : waitCnt_q + 32'd1;
        // Done takes priority over the watchdog when both land together.
        if (pp_done) begin
          path_d    = pp_final_path;
          timeout_d = 1'b0;
          state_d   = RESP;
        end else if (waitCnt_q == 32'(TIMEOUT_CYC - 1)) begin
          path_d      = '0;
          timeout_d   = 1'b1;
          abortPend_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and payload registers. Reset drops any in-flight query silently and
  // points the round-robin at the last requester so requester 0 goes first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rrPtr_q     <= IDW'(NUM_REQ - 1);
      id_q        <= '0;
      sNode_q     <= '0;
      eNode_q     <= '0;
      waitCnt_q   <= '0;
      path_q      <= '0;
      timeout_q   <= 1'b0;
      abortPend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rrPtr_q     <= rrPtr_d;
      id_q        <= id_d;
      sNode_q     <= sNode_d;
      eNode_q     <= eNode_d;
      waitCnt_q   <= waitCnt_d;
      path_q      <= path_d;
      timeout_q   <= timeout_d;
      abortPend_q <= abortPend_d;
    end
  end

  // Planner reset follows our own reset so both are always cleared together,
  // and is also pulsed on the first RESP cycle after a watchdog abort.
  always_comb begin
    req_ready   = (state_q == ARB) ? gnt : '0;
    pp_reset    = reset || (state_q == PRST) || ((state_q == RESP) && abortPend_q);
    pp_start    = (state_q == PRST) || (state_q == PSTART);
    pp_s_node   = sNode_q;
    pp_e_node   = eNode_q;
    rsp_valid   = (state_q == RESP);
    rsp_id      = id_q;
    rsp_path    = path_q;
    rsp_timeout = timeout_q;
    rsp_cycles  = waitCnt_q;
    busy        = (state_q != IDLE);
  end

endmodule

// File: tb/tb_path_query_scheduler.sv
// ---------------------------------------------------------------------------
// tb_path_query_scheduler
// Drives path_query_scheduler with a behavioural planner stand-in (fixed or
// never-ending latency, optionally keeping done high across its reset) and
// checks grants, handshake timing and response contents against a simple
// round-robin / latency model.
// ---------------------------------------------------------------------------
module tb_path_query_scheduler;

  localparam int NUM_REQ     = 4;
  localparam int NODE_W      = 5;
  localparam int PATH_LEN    = 10;
  localparam int TIMEOUT_CYC = 16;
  localparam int PW          = PATH_LEN * NODE_W;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*NODE_W-1:0] req_s_node = '0;
  logic [NUM_REQ*NODE_W-1:0] req_e_node = '0;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b0;
  logic [1:0]                rsp_id;
  logic [PW-1:0]             rsp_path;
  logic                      rsp_timeout;
  logic [31:0]               rsp_cycles;
  logic                      pp_reset;
  logic                      pp_start;
  logic [NODE_W-1:0]         pp_s_node;
  logic [NODE_W-1:0]         pp_e_node;
  logic                      pp_done = 1'b0;
  logic [PW-1:0]             pp_final_path = '0;
  logic                      busy;

  int checks = 0;
  int failures = 0;

  path_query_scheduler #(
    .NUM_REQ(NUM_REQ), .NODE_W(NODE_W), .PATH_LEN(PATH_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_s_node(req_s_node), .req_e_node(req_e_node),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_path(rsp_path), .rsp_timeout(rsp_timeout), .rsp_cycles(rsp_cycles),
    .pp_reset(pp_reset), .pp_start(pp_start), .pp_s_node(pp_s_node), .pp_e_node(pp_e_node),
    .pp_done(pp_done), .pp_final_path(pp_final_path), .busy(busy)
  );

  always #5 clk = ~clk;

  // Deterministic stand-in for the planner's result for a given query.
  function automatic logic [PW-1:0] pathOf(input logic [NODE_W-1:0] s, input logic [NODE_W-1:0] e);
    logic [PW-1:0] p;
    p = '0;
    for (int k = 0; k < PATH_LEN; k++)
      p[k*NODE_W +: NODE_W] = NODE_W'(int'(s) + k * (int'(e) + 3) + 1);
    return p;
  endfunction

  // Planner stand-in: starts on pp_start outside reset, raises done stubLat
  // cycles later and keeps it high until the next planner reset. In sticky
  // mode done and the old path survive that reset, mimicking a stale done.
  int               stubLat = 3;
  int               stubCnt = 0;
  bit               stubHang = 1'b0;
  bit               stubSticky = 1'b0;
  logic             stubRunning = 1'b0;
  logic [NODE_W-1:0] stubS = '0, stubE = '0;

  always @(posedge clk) begin
    if (pp_reset) begin
      stubRunning <= 1'b0;
      if (!stubSticky) begin
        pp_done       <= 1'b0;
        pp_final_path <= '0;
      end
    end else if (pp_start && !stubRunning) begin
      stubRunning <= 1'b1;
      stubCnt     <= 0;
      stubS       <= pp_s_node;
      stubE       <= pp_e_node;
      pp_done     <= 1'b0;
    end else if (stubRunning) begin
      stubCnt <= stubCnt + 1;
      if (!stubHang && stubCnt == stubLat - 1) begin
        pp_done       <= 1'b1;
        pp_final_path <= pathOf(stubS, stubE);
        stubRunning   <= 1'b0;
      end
    end
  end

  // Bench-side requester state and model of the round-robin pointer.
  logic [NODE_W-1:0] sN [NUM_REQ];
  logic [NODE_W-1:0] eN [NUM_REQ];
  int rrModel = NUM_REQ - 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int i, input logic [NODE_W-1:0] s, input logic [NODE_W-1:0] e, input bit v);
    sN[i] = s;
    eN[i] = e;
    req_s_node[i*NODE_W +: NODE_W] = s;
    req_e_node[i*NODE_W +: NODE_W] = e;
    req_valid[i] = v;
  endtask

  task automatic randomRequest(input int i);
    applyStimulus(i, NODE_W'($urandom_range(0, 18)), NODE_W'($urandom_range(0, 18)), 1'b1);
  endtask

  function automatic int expectWinner(input logic [NUM_REQ-1:0] mask, input int ptr);
    for (int k = 1; k <= NUM_REQ; k++)
      if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    rrModel = NUM_REQ - 1;
  endtask

  // Runs one full query from grant to response acceptance and checks every
  // phase against the model. reissue re-raises the served requester at once.
  task automatic serveOne(input int lat, input bit hang, input int rspDelay, input bit reissue, output int servedId);
    int n, g, expCyc;
    bit expTo, stable;
    logic [NODE_W-1:0] eS, eE;
    logic [PW-1:0] expPath;
    servedId = -1;
    stubLat = lat;
    stubHang = hang;
    n = 0;
    while (req_ready == '0 && n < 12) begin
      tick();
      n++;
    end
    if (req_ready == '0) begin
      checkOutput("grantBound", 64'(req_ready), 64'(1));
      return;
    end
    g = expectWinner(req_valid, rrModel);
    if (g < 0) begin
      checkOutput("grantNoReq", 64'(req_ready), 64'(0));
      return;
    end
    checkOutput("grant", 64'(req_ready), 64'(1 << g));
    eS = sN[g];
    eE = eN[g];
    rrModel = g;
    servedId = g;
    tick();
    req_valid[g] = 1'b0;
    if (reissue) randomRequest(g);
    checkOutput("prstCtl", 64'({pp_reset, pp_start, busy}), 64'(3'b111));
    checkOutput("ppNodes", 64'({pp_s_node, pp_e_node}), 64'({eS, eE}));
    tick();
    checkOutput("pstartCtl", 64'({pp_reset, pp_start}), 64'(2'b01));
    n = 0;
    do begin
      tick();
      n++;
    end while (!rsp_valid && n < 40);
    if (!rsp_valid) begin
      checkOutput("rspBound", 64'(rsp_valid), 64'(1));
      return;
    end
    expTo   = hang || (lat + 1 > TIMEOUT_CYC);
    expCyc  = expTo ? TIMEOUT_CYC : lat + 1;
    expPath = expTo ? '0 : pathOf(eS, eE);
    checkOutput("waitLen", 64'(n - 1), 64'(expCyc));
    checkOutput("rspId", 64'(rsp_id), 64'(g));
    checkOutput("rspPath", 64'(rsp_path), 64'(expPath));
    checkOutput("rspTimeout", 64'(rsp_timeout), 64'(expTo));
    checkOutput("rspCycles", 64'(rsp_cycles), 64'(expCyc));
    checkOutput("abortPulse", 64'(pp_reset), 64'(expTo));
    checkOutput("rspNodes", 64'({pp_s_node, pp_e_node}), 64'({eS, eE}));
    stable = 1'b1;
    for (int d = 0; d < rspDelay; d++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_path !== expPath || rsp_id !== 2'(g) ||
          rsp_timeout !== expTo || rsp_cycles !== 32'(expCyc) || req_ready !== '0 ||
          busy !== 1'b1 || pp_reset !== 1'b0 || pp_s_node !== eS || pp_e_node !== eE)
        stable = 1'b0;
    end
    if (rspDelay > 0) checkOutput("rspHold", 64'(stable), 64'(1));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("rspDone", 64'({rsp_valid, busy}), 64'(2'b00));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int id;
    int order [5];
    int expOrder [5];
    bit hang;
    expOrder = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, '0, '0, 1'b0);

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    checkOutput("resetOuts", 64'({busy, rsp_valid, req_ready, pp_start, rsp_timeout}), 64'(0));
    checkOutput("resetPath", 64'(rsp_path), 64'(0));
    checkOutput("resetPpReset", 64'(pp_reset), 64'(1));
    reset = 1'b0;
    rrModel = NUM_REQ - 1;
    tick();
    checkOutput("idlePpReset", 64'({pp_reset, busy}), 64'(0));

    // Single requester 0, s=0 e=11
    applyStimulus(0, 5'd0, 5'd11, 1'b1);
    serveOne(3, 1'b0, 0, 1'b0, id);
    checkOutput("t1Id", 64'(id), 64'(0));

    // All four continuously valid: strict rotation from requester 0
    doReset();
    for (int i = 0; i < NUM_REQ; i++) randomRequest(i);
    for (int q = 0; q < 5; q++) begin
      serveOne($urandom_range(1, 6), 1'b0, $urandom_range(0, 2), 1'b1, id);
      order[q] = id;
    end
    for (int q = 0; q < 5; q++) checkOutput("rrOrder", 64'(order[q]), 64'(expOrder[q]));
    req_valid = '0;
    tick();
    tick();

    // Planner never finishes, response back-pressured for 20 cycles
    applyStimulus(3, 5'd4, 5'd9, 1'b1);
    serveOne(1, 1'b1, 20, 1'b0, id);
    // Done exactly at the watchdog limit wins; one cycle earlier is plainly done
    applyStimulus(2, 5'd7, 5'd1, 1'b1);
    serveOne(TIMEOUT_CYC - 1, 1'b0, 1, 1'b0, id);
    applyStimulus(1, 5'd18, 5'd2, 1'b1);
    serveOne(TIMEOUT_CYC - 2, 1'b0, 0, 1'b0, id);

    // Reset while waiting on the planner
    applyStimulus(2, 5'd3, 5'd5, 1'b1);
    stubLat = 10;
    stubHang = 1'b0;
    while (req_ready == '0) tick();
    tick();
    req_valid = '0;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    checkOutput("midResetPp", 64'(pp_reset), 64'(1));
    tick();
    checkOutput("midResetOuts", 64'({busy, rsp_valid, pp_reset}), 64'(3'b001));
    reset = 1'b0;
    rrModel = NUM_REQ - 1;
    tick();
    applyStimulus(1, 5'd8, 5'd13, 1'b1);
    serveOne(4, 1'b0, 2, 1'b0, id);

    // Stale done carried into the next query must not be taken as its result
    applyStimulus(0, 5'd6, 5'd6, 1'b1);
    serveOne(2, 1'b0, 0, 1'b0, id);
    stubSticky = 1'b1;
    applyStimulus(3, 5'd12, 5'd17, 1'b1);
    serveOne(5, 1'b0, 0, 1'b0, id);
    stubSticky = 1'b0;

    // Randomized traffic
    for (int r = 0; r < 24; r++) begin
      if (req_valid == '0) begin
        for (int i = 0; i < NUM_REQ; i++)
          if ($urandom_range(0, 1) == 1) randomRequest(i);
        if (req_valid == '0) randomRequest($urandom_range(0, NUM_REQ - 1));
      end
      hang = ($urandom_range(0, 7) == 0);
      serveOne($urandom_range(1, 20), hang, $urandom_range(0, 3), bit'($urandom_range(0, 1)), id);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
